// File: rtl/game_pkg.sv
// Shared game definitions: tile/sequence widths and playback states.
// Also hosts tile_at(), used by playback and by the player input checker.
package game_pkg;

    localparam int TILE_W    = 2;
    localparam int SEQ_W     = 18;
    localparam int MAX_TILES = 9;
    localparam int LEN_W     = 4;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        GAP,
        FIN
    } state_t;

    // tile idx is {seq[2*idx], seq[2*idx+1]}, seq[2*idx] being the MSB
    function automatic logic [TILE_W-1:0] tile_at(
        input logic [SEQ_W-1:0] s,
        input logic [LEN_W-1:0] idx
    );
        logic [4:0] b;
        b = {idx, 1'b0};
        return {s[b], s[b+5'd1]};
    endfunction

endpackage

// File: rtl/seq_playback_tile_decoder.sv
// 2-to-4 one-hot tile decoder with enable.
// Enable low forces every tile dark.
module tile_decoder
    import game_pkg::*;
(
    input  logic              en,
    input  logic [TILE_W-1:0] tile,
    output logic [3:0]        onehot
);

    // light the selected tile only when enabled
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[tile] = 1'b1;
        end
    end

endmodule

// File: rtl/seq_playback.sv
// Plays the latched tile sequence: each tile lit ON_CYCLES, then GAP_CYCLES dark.
// Optional abort input enabled by defining SEQ_PLAYBACK_ABORT_EN.
module seq_playback
    import game_pkg::*;
#(
    parameter int ON_CYCLES  = 25000000,
    parameter int GAP_CYCLES = 12500000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [SEQ_W-1:0] seq,
    input  logic [LEN_W-1:0] round_len,
`ifdef SEQ_PLAYBACK_ABORT_EN
    input  logic             abort,
`endif
    output logic [3:0]       tile_on,
    output logic [LEN_W-1:0] seq_counter,
    output logic             busy,
    output logic             done
);

    localparam int TMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0]    ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0]    GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_TILES);

    state_t           state, state_d;
    logic [TW-1:0]    timer, timer_d;
    logic [LEN_W-1:0] cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] len_sat;
    logic [SEQ_W-1:0] seq_q, seq_src;
    logic             load;
    logic             lit_d;
    logic             busy_d;
    logic             done_d;
    logic [TILE_W-1:0] tile_d;
    logic [3:0]       tile_on_d;

    assign len_sat = (round_len > LEN_MAX) ? LEN_MAX : round_len;

    // state, timer, latched request and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            timer       <= '0;
            seq_q       <= '0;
            len_q       <= '0;
            seq_counter <= '0;
            tile_on     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            len_q       <= len_d;
            seq_counter <= cnt_d;
            tile_on     <= tile_on_d;
            busy        <= busy_d;
            done        <= done_d;
            if (load) begin
                seq_q <= seq;
            end
        end
    end

    // next state, timer and tile index
    always_comb begin
        state_d = state;
        timer_d = timer;
        cnt_d   = seq_counter;
        len_d   = len_q;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    len_d   = len_sat;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = (len_sat == '0) ? FIN : ON;
                end
            end
            ON: begin
                if (timer == ON_LAST) begin
                    timer_d = '0;
                    state_d = GAP;
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    timer_d = '0;
                    if (seq_counter == len_q - LEN_W'(1)) begin
                        state_d = FIN;
                    end else begin
                        cnt_d   = seq_counter + LEN_W'(1);
                        state_d = ON;
                    end
                end else begin
                    timer_d = timer + TW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef SEQ_PLAYBACK_ABORT_EN
        if (abort && (state == ON || state == GAP)) begin
            state_d = IDLE;
            timer_d = '0;
            cnt_d   = '0;
        end
`endif
    end

    // next registered outputs, derived from the upcoming state
    always_comb begin
        seq_src = load ? seq : seq_q;
        tile_d  = tile_at(seq_src, cnt_d);
        lit_d   = (state_d == ON);
        busy_d  = (state_d == ON) || (state_d == GAP);
        done_d  = (state_d == FIN);
    end

    tile_decoder u_dec (
        .en     (lit_d),
        .tile   (tile_d),
        .onehot (tile_on_d)
    );

endmodule
